// File: rtl/upe_mul16u_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upe_mul16u_seq_pkg
// Description : Shared definitions for the UPE sequential unsigned multiplier.
//               Holds the FSM state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package upe_mul16u_seq_pkg;

    // Default operand width; the product is twice this wide.
    localparam int UPE_WIDTH = 16;

    // Controller state encoding.
    localparam logic [1:0] UPE_ST_IDLE = 2'd0;
    localparam logic [1:0] UPE_ST_BUSY = 2'd1;
    localparam logic [1:0] UPE_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/upe_mul16u_seq_mulstep16.sv
`default_nettype none
// ============================================================================
// Module      : upe_mulstep16
// Description : One combinational shift-add multiply step. Adds the
//               multiplicand into the upper half of the accumulator when the
//               multiplier LSB is set, then shifts {carry, acc} right by one.
// Ports       : acc_hi      - upper WIDTH bits of the accumulator
//               acc_lo      - lower WIDTH bits of the accumulator
//               mcand       - multiplicand
//               mplr_lsb    - current multiplier LSB
//               acc_hi_next - upper half after add and shift
//               acc_lo_next - lower half after shift
// Revision    : 1.0 - initial release
// ============================================================================
module upe_mulstep16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] mcand,
    input  logic             mplr_lsb,
    output logic [WIDTH-1:0] acc_hi_next,
    output logic [WIDTH-1:0] acc_lo_next
);

    // WIDTH+1 bit sum keeps the carry out of the add.
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = {1'b0, acc_hi};
        if (mplr_lsb) begin
            w_sum = {1'b0, acc_hi} + {1'b0, mcand};
        end
        // The carry shifts into the top bit, the sum LSB into the low half.
        acc_hi_next = w_sum[WIDTH:1];
        acc_lo_next = {w_sum[0], acc_lo[WIDTH-1:1]};
    end

endmodule
`default_nettype wire

// File: rtl/upe_mul16u_seq.sv
`default_nettype none
// ============================================================================
// Module      : upe_mul16u_seq
// Description : Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add
//               multiplier with a valid/ready handshake on both sides. The
//               product sign is carried alongside unchanged. Fixed latency of
//               WIDTH clocks from accept to out_valid.
// Ports       : clk       - clock, rising edge
//               reset     - synchronous active-high reset
//               In1, In2  - multiplicand / multiplier magnitudes
//               sign_in   - product sign
//               in_valid  / in_ready  - operand handshake
//               Out       - unsigned product, held until the next completion
//               sign_out  - sign registered with the product
//               out_valid / out_ready - result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module upe_mul16u_seq
    import upe_mul16u_seq_pkg::*;
#(
    parameter int WIDTH = UPE_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   In1,
    input  logic [WIDTH-1:0]   In2,
    input  logic               sign_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] Out,
    output logic               sign_out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]         state_q,    state_d;
    logic [CW-1:0]      counter_q,  counter_d;
    logic [WIDTH-1:0]   mcand_q,    mcand_d;
    logic [WIDTH-1:0]   mplr_q,     mplr_d;
    logic [2*WIDTH-1:0] acc_q,      acc_d;
    logic               sign_lat_q, sign_lat_d;
    logic [2*WIDTH-1:0] out_q,      out_d;
    logic               sign_out_q, sign_out_d;

    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic               w_accept;
    logic               w_last;

    upe_mulstep16 #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi      (acc_q[2*WIDTH-1:WIDTH]),
        .acc_lo      (acc_q[WIDTH-1:0]),
        .mcand       (mcand_q),
        .mplr_lsb    (mplr_q[0]),
        .acc_hi_next (w_step_hi),
        .acc_lo_next (w_step_lo)
    );

    assign w_accept = (state_q == UPE_ST_IDLE) && in_valid;
    assign w_last   = (counter_q == C_LAST_STEP);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UPE_ST_IDLE;
            counter_q  <= '0;
            mcand_q    <= '0;
            mplr_q     <= '0;
            acc_q      <= '0;
            sign_lat_q <= 1'b0;
            out_q      <= '0;
            sign_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            mcand_q    <= mcand_d;
            mplr_q     <= mplr_d;
            acc_q      <= acc_d;
            sign_lat_q <= sign_lat_d;
            out_q      <= out_d;
            sign_out_q <= sign_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            UPE_ST_IDLE: if (w_accept)  state_d = UPE_ST_BUSY;
            UPE_ST_BUSY: if (w_last)    state_d = UPE_ST_DONE;
            UPE_ST_DONE: if (out_ready) state_d = UPE_ST_IDLE;
            default:                    state_d = UPE_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        counter_d  = counter_q;
        mcand_d    = mcand_q;
        mplr_d     = mplr_q;
        acc_d      = acc_q;
        sign_lat_d = sign_lat_q;
        out_d      = out_q;
        sign_out_d = sign_out_q;
        case (state_q)
            UPE_ST_IDLE: begin
                if (w_accept) begin
                    mcand_d    = In1;
                    mplr_d     = In2;
                    sign_lat_d = sign_in;
                    acc_d      = '0;
                    counter_d  = '0;
                end
            end
            UPE_ST_BUSY: begin
                acc_d     = {w_step_hi, w_step_lo};
                mplr_d    = mplr_q >> 1;
                counter_d = counter_q + CW'(1);
                // The final step's result goes straight to the output register
                // so out_valid and Out appear on the same edge.
                if (w_last) begin
                    out_d      = {w_step_hi, w_step_lo};
                    sign_out_d = sign_lat_q;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from state only
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            UPE_ST_IDLE: in_ready  = 1'b1;
            UPE_ST_DONE: out_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign Out      = out_q;
    assign sign_out = sign_out_q;

endmodule
`default_nettype wire

// File: tb/tb_upe_mul16u_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_upe_mul16u_seq
// Description : Self-checking bench for upe_mul16u_seq. Expected products are
//               queued when operands are accepted and compared on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upe_mul16u_seq;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   In1;
    logic [W-1:0]   In2;
    logic           sign_in;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] Out;
    logic           sign_out;
    logic           out_valid;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;

    logic [2*W:0] sb_q[$];   // {sign, product}

    upe_mul16u_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .In1       (In1),
        .In2       (In2),
        .sign_in   (sign_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Out       (Out),
        .sign_out  (sign_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one operation. Stimulus changes on negedge, outputs sampled on negedge.
    // stall: cycles out_ready is held low in DONE. glitch: drive 9x9 while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int stall, input bit glitch);
        int k;
        logic [2*W:0]   expv;
        logic [2*W-1:0] held;
        chk("in_ready_before", 64'(in_ready), 64'd1);
        In1 = a; In2 = b; sign_in = s; in_valid = 1'b1;
        out_ready = (stall == 0);
        sb_q.push_back({s, 32'(a) * 32'(b)});
        @(posedge clk);
        @(negedge clk);
        if (glitch) begin
            In1 = 16'd9; In2 = 16'd9; sign_in = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (glitch && k == 2) chk("in_ready_busy", 64'(in_ready), 64'd0);
            if (glitch && k == 5) in_valid = 1'b0;
        end
        chk("latency", 64'(k), 64'(W));
        expv = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("product", 64'(Out), 64'(expv[2*W-1:0]));
        chk("sign", 64'(sign_out), 64'(expv[2*W]));
        held = Out;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_hold", {31'd0, in_ready, out_valid, Out},
                {31'd0, 1'b0, 1'b1, held});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("back_idle", {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        logic [2*W-1:0] resigned;
        int extra;
        reset = 1'b1; In1 = '0; In2 = '0; sign_in = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {30'd0, in_ready, out_valid, sign_out, Out[30:0]},
            {30'd0, 1'b1, 1'b0, 1'b0, 31'd0});
        chk("reset_out", 64'(Out), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(16'd3, 16'd5, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        resigned = sign_out ? (~Out + 32'd1) : Out;
        chk("resign_chain", 64'(resigned), 64'h0001FFFF);
        run_op(16'h1234, 16'h0100, 1'b0, 5, 1'b0);

        // Reset in the middle of a BUSY operation discards it.
        In1 = 16'h00FF; In2 = 16'h00FF; sign_in = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset", {61'd0, in_ready, out_valid, sign_out}, 64'b100);
        chk("midreset_out", 64'(Out), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        run_op(16'd2, 16'd7, 1'b0, 0, 1'b0);

        // Operands offered while busy must be ignored.
        run_op(16'd4, 16'd4, 1'b0, 0, 1'b1);
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("no_extra_result", 64'(extra), 64'd0);

        run_op(16'd0, 16'h1234, 1'b1, 0, 1'b0);
        run_op(16'h8000, 16'h0002, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), i, 1'b0);
        end
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
